param_seq_timer: RTL and testbench

PARAM_SEQ_TIMER -- requirements
Module: param_seq_timer

---
 rtl/param_seq_timer.sv | 221 ++++++++++++++++++++++
 tb/tb_param_seq_timer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_timer.sv
// ---------------------------------------------------------------------------
// param_seq_timer
//
// Serial start-pattern detector followed by a programmable delay timer.
// Operation:
//   SEARCH : the serial stream is shifted into a PAT_LEN-bit history
//            register. When the history equals PATTERN the FSM moves on.
//            Overlapping matches are detected.
//   SHIFT  : the next DELAY_W bits of the stream are shifted in, MSB first,
//            to form the delay value.
//   COUNT  : counting is high for (delay+1)*TICKS_PER_UNIT cycles. The
//            period is timed by a tick counter nested inside a unit
//            down-counter, so no multiplier is needed.
//   DONE   : done is high until ack is sampled high.
//
// Parameters:
//   PAT_LEN        start-pattern length in bits (2..16)
//   PATTERN        start pattern, MSB received first
//   DELAY_W        delay field width in bits (1..8)
//   TICKS_PER_UNIT clock cycles per delay unit (2..65535)
//
// Ports:
//   clk        clock; all logic runs on the rising edge
//   reset      synchronous, active-high reset
//   data       serial input stream, sampled on every edge
//   ack        acknowledge of done; it only has an effect in DONE
//   abort      (only with PARAM_SEQ_TIMER_ABORT_EN) abandons SHIFT/COUNT
//   counting   high while the timer runs
//   done       high after timeout until acknowledged
//   remaining  whole units left in the current count; 0 outside COUNT
//
// Build option:
//   PARAM_SEQ_TIMER_ABORT_EN  adds the abort input. Without this macro the
//                             port is absent and abort behaves as if tied 0.
// ---------------------------------------------------------------------------
module param_seq_timer #(
  parameter int                 PAT_LEN        = 4,
  parameter logic [PAT_LEN-1:0] PATTERN        = 4'b1101,
  parameter int                 DELAY_W        = 4,
  parameter int                 TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
`ifdef PARAM_SEQ_TIMER_ABORT_EN
  input  logic               abort,
`endif
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] remaining
);

  // Counter widths. TICKS_PER_UNIT is at least 2, so TICK_W is at least 1.
  // BIT_W must hold DELAY_W-1, and it is kept at a minimum of 1 bit.
  localparam int TICK_W = $clog2(TICKS_PER_UNIT);
  localparam int BIT_W  = $clog2(DELAY_W + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [PAT_LEN-1:0]   hist;
  logic [PAT_LEN-1:0]   hist_shift;
  logic [DELAY_W-1:0]   delay;
  logic [DELAY_W-1:0]   delay_shift;
  logic [DELAY_W:0]     delay_cat;
  logic [BIT_W-1:0]     bit_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [DELAY_W-1:0]   unit_cnt;

  logic                 pat_hit;
  logic                 last_bit;
  logic                 tick_wrap;
  logic                 unit_last;
  logic                 abort_req;

`ifdef PARAM_SEQ_TIMER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Shift-in helpers and counter terminal conditions
  // -------------------------------------------------------------------------
  // The match is tested on the history after the current bit is included.
  // As a result, detection happens on the same edge that samples the last
  // pattern bit.
  assign hist_shift  = {hist[PAT_LEN-2:0], data};
  assign pat_hit     = (hist_shift == PATTERN);

  // Concatenating and then truncating avoids a zero-width slice when
  // DELAY_W == 1.
  assign delay_cat   = {delay, data};
  assign delay_shift = delay_cat[DELAY_W-1:0];

  assign last_bit    = (bit_cnt == BIT_LAST);
  assign tick_wrap   = (tick_cnt == TICK_LAST);
  assign unit_last   = (unit_cnt == '0);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: begin
        if (pat_hit) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (abort_req)     state_nxt = SEARCH;
        else if (last_bit) state_nxt = COUNT;
      end
      COUNT: begin
        // The final unit is the one where unit_cnt has reached 0. The count
        // ends when the tick counter wraps within that unit.
        if (abort_req)                   state_nxt = SEARCH;
        else if (tick_wrap && unit_last) state_nxt = DONE;
      end
      DONE: begin
        if (ack) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // History register
  // -------------------------------------------------------------------------
  // The history only accumulates while the FSM stays in SEARCH. In every
  // other case it is held at zero. Each new search therefore starts clean,
  // and stale pattern bits cannot combine with fresh ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
    end else if (state == SEARCH && state_nxt == SEARCH) begin
      hist <= hist_shift;
    end else begin
      hist <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Delay capture and the tick/unit counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      delay    <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else if (state_nxt == SEARCH) begin
      // This covers idle search, ack in DONE and abort. Everything restarts
      // from zero.
      delay    <= '0;
      bit_cnt  <= '0;
      tick_cnt <= '0;
      unit_cnt <= '0;
    end else begin
      case (state)
        SHIFT: begin
          delay   <= delay_shift;
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (last_bit) begin
            // Load the unit counter with the completed delay value, so COUNT
            // starts with remaining == delay.
            unit_cnt <= delay_shift;
            tick_cnt <= '0;
          end
        end
        COUNT: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (!unit_last) unit_cnt <= unit_cnt - DELAY_W'(1);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DONE: begin
          bit_cnt  <= '0;
          tick_cnt <= '0;
          unit_cnt <= '0;
        end
        default: begin
          // SEARCH moving to SHIFT: the shift begins with a clean bit count.
          bit_cnt  <= '0;
          tick_cnt <= '0;
          unit_cnt <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The outputs are decoded from registered state only. No input reaches an
  // output combinationally.
  assign counting  = (state == COUNT);
  assign done      = (state == DONE);
  assign remaining = (state == COUNT) ? unit_cnt : '0;

endmodule

// File: tb/tb_param_seq_timer.sv
module tb_param_seq_timer;

  localparam int T = 1000;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       data  = 1'b0;
  logic       ack   = 1'b0;
  logic       counting, done;
  logic [3:0] remaining;

  logic       data2 = 1'b0;
  logic       ack2  = 1'b0;
  logic       counting2, done2;
  logic [1:0] remaining2;

`ifdef PARAM_SEQ_TIMER_ABORT_EN
  logic abort  = 1'b0;
  logic abort2 = 1'b0;
`endif

  param_seq_timer u_dut (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
`ifdef PARAM_SEQ_TIMER_ABORT_EN
    .abort(abort),
`endif
    .counting(counting), .done(done), .remaining(remaining)
  );

  param_seq_timer #(.PAT_LEN(3), .PATTERN(3'b101), .DELAY_W(2), .TICKS_PER_UNIT(5)) u_small (
    .clk(clk), .reset(reset), .data(data2), .ack(ack2),
`ifdef PARAM_SEQ_TIMER_ABORT_EN
    .abort(abort2),
`endif
    .counting(counting2), .done(done2), .remaining(remaining2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int start;
    int len;
    int rem0;
    bit done_after;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one expected record is popped for each counting run of the main
  // DUT. The monitor checks the start cycle, the per-unit remaining value,
  // the run length, and the state that follows the run.
  initial begin
    bit   run;
    exp_t cur;
    int   run_len;
    int   rem_err;
    run     = 0;
    run_len = 0;
    rem_err = 0;
    cur     = '{0, 0, 0, 1'b0};
    forever begin
      @(negedge clk);
      if (counting === 1'b1 && !run) begin
        run     = 1;
        run_len = 0;
        rem_err = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_count_start", cyc, -1);
          cur = '{cyc, 0, 0, 1'b0};
        end else begin
          cur = sbq.pop_front();
          chk("count_start_cycle", cyc, cur.start);
        end
      end
      if (run && counting === 1'b1) begin
        if (int'(remaining) != cur.rem0 - run_len / T) rem_err++;
        run_len++;
      end else if (run) begin
        run = 0;
        chk("count_length", run_len, cur.len);
        chk("remaining_value_errors", rem_err, 0);
        chk("done_after_count", int'(done), int'(cur.done_after));
        chk("remaining_after_count", int'(remaining), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data = v[i];
      step();
    end
    data = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int c0;
    int h;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_counting", int'(counting), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_remaining", int'(remaining), 0);
    step();

    // Small configuration: maximum delay 3 -> 4 units of 5 cycles each.
    begin
      logic [4:0] bits2;
      int         first;
      int         n;
      int         seq[$];
      int         packed_seq;
      bits2 = 5'b101_11;
      c0    = cyc;
      for (int i = 4; i >= 0; i--) begin
        data2 = bits2[i];
        step();
      end
      data2 = 1'b0;
      first = -1;
      n     = 0;
      for (int i = 0; i < 40; i++) begin
        if (counting2 === 1'b1) begin
          if (first < 0) first = cyc;
          n++;
          if (seq.size() == 0 || seq[$] != int'(remaining2)) seq.push_back(int'(remaining2));
        end
        step();
      end
      packed_seq = (seq.size() == 4) ? seq[0] * 1000 + seq[1] * 100 + seq[2] * 10 + seq[3] : -1;
      chk("small_start_cycle", first, c0 + 5);
      chk("small_count_length", n, 20);
      chk("small_remaining_seq", packed_seq, 3210);
      chk("small_done", int'(done2), 1);
      ack2 = 1'b1;
      step();
      ack2 = 1'b0;
      chk("small_done_acked", int'(done2), 0);
    end

    // Nominal run: pattern 1101, delay 0010.
    c0 = cyc;
    sbq.push_back('{c0 + 8, 3000, 2, 1'b1});
    drive_bits(16'b1101_0010, 8);
    wait_done("nominal_done_timeout");
    chk("nominal_done_cycle", cyc, c0 + 3008);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("nominal_done_cleared", int'(done), 0);

    // Overlapping detection (11101), delay 0; done holds while ack is low.
    c0 = cyc;
    sbq.push_back('{c0 + 9, 1000, 0, 1'b1});
    drive_bits(16'b11101_0000, 9);
    wait_done("overlap_done_timeout");
    h = 0;
    repeat (50) begin
      if (done === 1'b1) h++;
      step();
    end
    chk("done_hold_50", h, 50);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("overlap_ack_done", int'(done), 0);
    chk("overlap_ack_counting", int'(counting), 0);

    // Reset at COUNT cycle 500 (delay 3).
    c0 = cyc;
    sbq.push_back('{c0 + 8, 501, 3, 1'b0});
    drive_bits(16'b1101_0011, 8);
    repeat (500) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_counting", int'(counting), 0);
    chk("midreset_remaining", int'(remaining), 0);
    drive_bits(16'b101, 3);
    repeat (20) step();
    chk("midreset_no_restart", int'(counting), 0);

    // Stray ack throughout; then "101" right after DONE must not trigger.
    ack = 1'b1;
    c0  = cyc;
    sbq.push_back('{c0 + 8, 2000, 1, 1'b1});
    drive_bits(16'b1101_0001, 8);
    wait_done("strayack_done_timeout");
    chk("strayack_done_cycle", cyc, c0 + 2008);
    step();
    chk("strayack_left_done", int'(done), 0);
    drive_bits(16'b101, 3);
    repeat (20) step();
    chk("history_cleared_no_trigger", int'(counting), 0);
    ack = 1'b0;

`ifdef PARAM_SEQ_TIMER_ABORT_EN
    // Abort at SHIFT bit 2.
    drive_bits(16'b1101, 4);
    drive_bits(16'b10, 2);
    abort = 1'b1;
    data  = 1'b1;
    step();
    abort = 1'b0;
    data  = 1'b0;
    chk("abort_shift_done", int'(done), 0);
    repeat (20) step();
    chk("abort_shift_no_count", int'(counting), 0);
    // Abort at COUNT cycle 10.
    c0 = cyc;
    sbq.push_back('{c0 + 8, 11, 0, 1'b0});
    drive_bits(16'b1101_0000, 8);
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_count_counting", int'(counting), 0);
    repeat (5) step();
    chk("abort_count_done", int'(done), 0);
`endif

    repeat (5) step();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
